// File: rtl/mem_stage_access_pkg.sv
// mem_stage_access_pkg
//   Shared definitions for the MEM-stage data-memory access block:
//   load/store opcodes, access size encoding, FSM state encoding and
//   small decode helpers used by the top level.
package mem_stage_access_pkg;

   localparam logic [5:0] OP_LB  = 6'h20;
   localparam logic [5:0] OP_LH  = 6'h21;
   localparam logic [5:0] OP_LW  = 6'h23;
   localparam logic [5:0] OP_LBU = 6'h24;
   localparam logic [5:0] OP_LHU = 6'h25;
   localparam logic [5:0] OP_SB  = 6'h28;
   localparam logic [5:0] OP_SH  = 6'h29;
   localparam logic [5:0] OP_SW  = 6'h2B;

   typedef enum logic [1:0] {
      SZ_BYTE,
      SZ_HALF,
      SZ_WORD
   } size_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACCESS,
      ST_DONE
   } state_t;

   // Unknown opcodes arriving with a strobe are handled as full words.
   function automatic size_t decode_size(input logic [5:0] op);
      case (op)
         OP_LB, OP_LBU, OP_SB: return SZ_BYTE;
         OP_LH, OP_LHU, OP_SH: return SZ_HALF;
         OP_LW, OP_SW:         return SZ_WORD;
         default:              return SZ_WORD;
      endcase
   endfunction

   function automatic logic is_signed_load(input logic [5:0] op);
      return (op == OP_LB) || (op == OP_LH);
   endfunction

endpackage

// File: rtl/mem_stage_access_if.sv
// mem_stage_access_if
//   Single-outstanding request/acknowledge data-memory bus.
//   master: drives bus_req, bus_we, bus_addr, bus_wdata, bus_be;
//           receives bus_ack (one-cycle completion) and bus_rdata.
//   slave : the memory side of the same signals.
interface mem_stage_access_if;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [3:0]  bus_be;
   logic        bus_ack;
   logic [31:0] bus_rdata;

   modport master (
      output bus_req, bus_we, bus_addr, bus_wdata, bus_be,
      input  bus_ack, bus_rdata
   );

   modport slave (
      input  bus_req, bus_we, bus_addr, bus_wdata, bus_be,
      output bus_ack, bus_rdata
   );
endinterface

// File: rtl/mem_lane_align.sv
// mem_lane_align
//   Combinational little-endian byte-lane handling shared by the store and
//   load paths.
//   size      : access size (byte/half/word)
//   lane      : byte address bits [1:0]
//   sign      : sign-extend sub-word load data when set
//   wdata     : raw store data (rt)
//   rdata     : raw word read from memory
//   be        : store byte enables for this size/lane
//   wdata_rep : store data replicated into every lane it could occupy
//   load_ext  : selected lane(s) of rdata, sign- or zero-extended
module mem_lane_align
   import mem_stage_access_pkg::*;
(
   input  size_t       size,
   input  logic [1:0]  lane,
   input  logic        sign,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata,
   output logic [3:0]  be,
   output logic [31:0] wdata_rep,
   output logic [31:0] load_ext
);

   logic [7:0]  rbyte [4];
   logic [7:0]  sel_byte;
   logic [15:0] sel_half;

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         assign rbyte[gi] = rdata[gi*8 +: 8];
      end
   endgenerate

   assign sel_byte = rbyte[lane];
   // Halfwords are aligned, so only addr[1] picks the half.
   assign sel_half = lane[1] ? rdata[31:16] : rdata[15:0];

   always_comb begin
      be        = 4'b1111;
      wdata_rep = wdata;
      load_ext  = rdata;
      case (size)
         SZ_BYTE: begin
            be        = 4'b0001 << lane;
            wdata_rep = {4{wdata[7:0]}};
            load_ext  = {{24{sign & sel_byte[7]}}, sel_byte};
         end
         SZ_HALF: begin
            be        = lane[1] ? 4'b1100 : 4'b0011;
            wdata_rep = {2{wdata[15:0]}};
            load_ext  = {{16{sign & sel_half[15]}}, sel_half};
         end
         default: begin
            be        = 4'b1111;
            wdata_rep = wdata;
            load_ext  = rdata;
         end
      endcase
   end

endmodule

// File: rtl/mem_stage_access.sv
// mem_stage_access
//   MEM-stage load/store engine. Converts an EX/MEM load or store into one
//   request/acknowledge transaction on the data bus, stalls the pipeline
//   while it is in flight and returns aligned, extended load data.
//   clk, rst    : clock and synchronous active-high reset
//   memr_in/memw_in, addr_in, wdata_in, instr_in : EX/MEM register outputs
//   bus         : data-memory bus (master side)
//   load_data/load_valid : extended load result, valid for one cycle
//   mem_stall   : holds the upstream pipeline registers
//   addr_err    : misaligned/illegal access seen in IDLE (combinational)
//   bus_timeout : one-cycle pulse when an access is aborted without ack
module mem_stage_access
   import mem_stage_access_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int TO_W           = 8
)
(
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      memr_in,
   input  logic                      memw_in,
   input  logic [31:0]               addr_in,
   input  logic [31:0]               wdata_in,
   input  logic [31:0]               instr_in,
   mem_stage_access_if.master        bus,
   output logic [31:0]               load_data,
   output logic                      load_valid,
   output logic                      mem_stall,
   output logic                      addr_err,
   output logic                      bus_timeout
);

   localparam logic [TO_W-1:0] CNT_LAST = TO_W'(TIMEOUT_CYCLES - 1);

   state_t            state_reg, state_next;
   logic              req_reg, req_next;
   logic              we_reg, we_next;
   logic [31:0]       addr_reg, addr_next;
   logic [31:0]       wdata_reg, wdata_next;
   logic [3:0]        be_reg, be_next;
   logic [TO_W-1:0]   cnt_reg, cnt_next;
   logic [31:0]       load_data_reg, load_data_next;
   logic              load_valid_reg, load_valid_next;
   logic              timeout_reg, timeout_next;
   size_t             size_reg, size_next;
   logic              sign_reg, sign_next;
   logic [1:0]        lane_reg, lane_next;
   logic              is_load_reg, is_load_next;

   logic [5:0]        opcode;
   size_t             size_live;
   logic              strobe;
   logic              misaligned;
   logic              start;
   logic              in_idle;

   size_t             size_sel;
   logic [1:0]        lane_sel;
   logic              sign_sel;
   logic [3:0]        be_st;
   logic [31:0]       wdata_rep;
   logic [31:0]       load_ext;

   logic              unused_instr;
   assign unused_instr = &{1'b0, instr_in[25:0]};

   assign opcode    = instr_in[31:26];
   assign size_live = decode_size(opcode);
   assign strobe    = memr_in | memw_in;
   assign in_idle   = (state_reg == ST_IDLE);

   assign misaligned = (memr_in & memw_in)
                     | ((size_live == SZ_WORD) & (addr_in[1:0] != 2'b00))
                     | ((size_live == SZ_HALF) & addr_in[0]);

   assign start     = in_idle & strobe & ~misaligned;
   assign addr_err  = in_idle & strobe & misaligned;
   assign mem_stall = start | (state_reg == ST_ACCESS);

   // One aligner serves both paths: in IDLE it shapes the outgoing store
   // from live inputs; afterwards it extends read data using the size and
   // lane captured when the access was launched.
   assign size_sel = in_idle ? size_live               : size_reg;
   assign lane_sel = in_idle ? addr_in[1:0]            : lane_reg;
   assign sign_sel = in_idle ? is_signed_load(opcode)  : sign_reg;

   mem_lane_align u_align (
      .size      (size_sel),
      .lane      (lane_sel),
      .sign      (sign_sel),
      .wdata     (wdata_in),
      .rdata     (bus.bus_rdata),
      .be        (be_st),
      .wdata_rep (wdata_rep),
      .load_ext  (load_ext)
   );

   always_comb begin
      state_next      = state_reg;
      req_next        = req_reg;
      we_next         = we_reg;
      addr_next       = addr_reg;
      wdata_next      = wdata_reg;
      be_next         = be_reg;
      cnt_next        = cnt_reg;
      load_data_next  = load_data_reg;
      load_valid_next = 1'b0;
      timeout_next    = 1'b0;
      size_next       = size_reg;
      sign_next       = sign_reg;
      lane_next       = lane_reg;
      is_load_next    = is_load_reg;

      case (state_reg)
         ST_IDLE: begin
            if (start) begin
               addr_next    = {addr_in[31:2], 2'b00};
               we_next      = memw_in;
               be_next      = memw_in ? be_st : 4'b1111;
               wdata_next   = wdata_rep;
               req_next     = 1'b1;
               cnt_next     = '0;
               size_next    = size_live;
               sign_next    = is_signed_load(opcode);
               lane_next    = addr_in[1:0];
               is_load_next = memr_in;
               state_next   = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            // Ack is tested first so it wins over a simultaneous timeout.
            if (bus.bus_ack) begin
               req_next        = 1'b0;
               if (is_load_reg) begin
                  load_data_next = load_ext;
               end
               load_valid_next = is_load_reg;
               state_next      = ST_DONE;
            end else if (cnt_reg == CNT_LAST) begin
               req_next        = 1'b0;
               timeout_next    = 1'b1;
               load_data_next  = '0;
               load_valid_next = is_load_reg;
               state_next      = ST_DONE;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         ST_DONE: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= ST_IDLE;
         req_reg        <= 1'b0;
         we_reg         <= 1'b0;
         addr_reg       <= '0;
         wdata_reg      <= '0;
         be_reg         <= 4'b0000;
         cnt_reg        <= '0;
         load_data_reg  <= '0;
         load_valid_reg <= 1'b0;
         timeout_reg    <= 1'b0;
         size_reg       <= SZ_WORD;
         sign_reg       <= 1'b0;
         lane_reg       <= 2'b00;
         is_load_reg    <= 1'b0;
      end else begin
         state_reg      <= state_next;
         req_reg        <= req_next;
         we_reg         <= we_next;
         addr_reg       <= addr_next;
         wdata_reg      <= wdata_next;
         be_reg         <= be_next;
         cnt_reg        <= cnt_next;
         load_data_reg  <= load_data_next;
         load_valid_reg <= load_valid_next;
         timeout_reg    <= timeout_next;
         size_reg       <= size_next;
         sign_reg       <= sign_next;
         lane_reg       <= lane_next;
         is_load_reg    <= is_load_next;
      end
   end

   assign bus.bus_req   = req_reg;
   assign bus.bus_we    = we_reg;
   assign bus.bus_addr  = addr_reg;
   assign bus.bus_wdata = wdata_reg;
   assign bus.bus_be    = be_reg;
   assign load_data     = load_data_reg;
   assign load_valid    = load_valid_reg;
   assign bus_timeout   = timeout_reg;

endmodule

// File: tb/tb_mem_stage_access.sv
// tb_mem_stage_access
//   Directed plus randomized bench for mem_stage_access. Expected values
//   come from a byte-arithmetic reference model of the load/store rules.
module tb_mem_stage_access;
   import mem_stage_access_pkg::*;

   localparam int TIMEOUT = 255;

   logic        clk;
   logic        rst;
   logic        memr_in;
   logic        memw_in;
   logic [31:0] addr_in;
   logic [31:0] wdata_in;
   logic [31:0] instr_in;
   logic [31:0] load_data;
   logic        load_valid;
   logic        mem_stall;
   logic        addr_err;
   logic        bus_timeout;

   int          checks;
   int          errors;
   logic [31:0] exp_load;

   mem_stage_access_if bus_if ();

   mem_stage_access #(
      .TIMEOUT_CYCLES (TIMEOUT),
      .TO_W           (8)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .memr_in     (memr_in),
      .memw_in     (memw_in),
      .addr_in     (addr_in),
      .wdata_in    (wdata_in),
      .instr_in    (instr_in),
      .bus         (bus_if),
      .load_data   (load_data),
      .load_valid  (load_valid),
      .mem_stall   (mem_stall),
      .addr_err    (addr_err),
      .bus_timeout (bus_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: observed no finish, expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_bit(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // Reference model: size from opcode, lanes via byte offsets and masks.
   function automatic void model(input logic [5:0] op, input logic r, input logic w,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] rdata,
                                 output logic err, output logic [3:0] be,
                                 output logic [31:0] wd, output logic [31:0] ld);
      int unsigned size;
      int unsigned off;
      logic [31:0] mask;
      logic [31:0] v;
      case (op)
         OP_LB, OP_LBU, OP_SB: size = 1;
         OP_LH, OP_LHU, OP_SH: size = 2;
         default:              size = 4;
      endcase
      off = addr % 4;
      err = (r && w) || ((addr % size) != 0);
      if (!w || size == 4) be = 4'hF;
      else if (size == 2)  be = 4'(3 << off);
      else                 be = 4'(1 << off);
      mask = (size == 4) ? 32'hFFFF_FFFF : (size == 2) ? 32'h0000_FFFF : 32'h0000_00FF;
      wd = (size == 4) ? wdata :
           (size == 2) ? (wdata & mask) * 32'h0001_0001 : (wdata & mask) * 32'h0101_0101;
      v = (rdata >> (8 * off)) & mask;
      if ((op == OP_LB || op == OP_LH) && v > (mask >> 1)) v = v | ~mask;
      ld = v;
   endfunction

   task automatic check_reset_state();
      check_bit("rst_bus_req", bus_if.bus_req, 1'b0);
      check_bit("rst_bus_we", bus_if.bus_we, 1'b0);
      check("rst_bus_addr", bus_if.bus_addr, 32'h0);
      check("rst_bus_wdata", bus_if.bus_wdata, 32'h0);
      check("rst_bus_be", 32'(bus_if.bus_be), 32'h0);
      check("rst_load_data", load_data, 32'h0);
      check_bit("rst_load_valid", load_valid, 1'b0);
      check_bit("rst_bus_timeout", bus_timeout, 1'b0);
      check_bit("rst_mem_stall", mem_stall, 1'b0);
   endtask

   // ack_n: ack driven in the ack_n-th ACCESS cycle; 0 or > TIMEOUT means never.
   task automatic txn(input logic [5:0] op, input logic r, input logic w,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] rdata, input int ack_n);
      logic        err;
      logic [3:0]  be;
      logic [31:0] wd;
      logic [31:0] ld;
      bit          tmo;
      bit          hold_ok;
      int          len;
      int          stalls;
      model(op, r, w, addr, wdata, rdata, err, be, wd, ld);
      tmo = (ack_n < 1) || (ack_n > TIMEOUT);
      len = tmo ? TIMEOUT : ack_n;

      @(negedge clk);
      memr_in  = r;
      memw_in  = w;
      addr_in  = addr;
      wdata_in = wdata;
      instr_in = {op, 26'($urandom)};
      #1;
      $display("txn op=%h r=%0d w=%0d addr=%h wdata=%h rdata=%h ack_n=%0d err=%0d",
               op, r, w, addr, wdata, rdata, ack_n, err);
      check_bit("addr_err", addr_err, err);
      check_bit("stall_idle", mem_stall, !err);
      if (err) begin
         @(posedge clk);
         #1 memr_in = 1'b0;
         memw_in = 1'b0;
         @(negedge clk);
         check_bit("no_req_on_err", bus_if.bus_req, 1'b0);
         return;
      end

      stalls  = mem_stall ? 1 : 0;
      hold_ok = 1'b1;
      @(posedge clk);
      #1 memr_in = 1'b0;
      memw_in = 1'b0;
      for (int k = 1; k <= len; k++) begin
         @(negedge clk);
         if (mem_stall) stalls++;
         if (bus_if.bus_req !== 1'b1 || bus_if.bus_addr !== {addr[31:2], 2'b00} ||
             bus_if.bus_be !== be || bus_if.bus_we !== w) hold_ok = 1'b0;
         if (k == 1) begin
            check_bit("bus_req", bus_if.bus_req, 1'b1);
            check_bit("bus_we", bus_if.bus_we, w);
            check("bus_addr", bus_if.bus_addr, {addr[31:2], 2'b00});
            check("bus_be", 32'(bus_if.bus_be), 32'(be));
            if (w) check("bus_wdata", bus_if.bus_wdata, wd);
         end
         if (k == len && !tmo) begin
            bus_if.bus_ack   = 1'b1;
            bus_if.bus_rdata = rdata;
         end
         @(posedge clk);
         #1 bus_if.bus_ack = 1'b0;
         bus_if.bus_rdata = $urandom;
      end

      if (tmo) exp_load = 32'h0;
      else if (r) exp_load = ld;

      @(negedge clk);
      check_bit("bus_stable", hold_ok, 1'b1);
      check_bit("load_valid_done", load_valid, r);
      check("load_data_done", load_data, exp_load);
      check_bit("timeout_done", bus_timeout, tmo);
      check_bit("req_done", bus_if.bus_req, 1'b0);
      check_bit("stall_done", mem_stall, 1'b0);
      check("stall_cycles", 32'(stalls), 32'(len + 1));

      // A stray ack back in IDLE must have no effect.
      @(posedge clk);
      #1 bus_if.bus_ack = 1'b1;
      @(negedge clk);
      check_bit("load_valid_pulse_end", load_valid, 1'b0);
      check_bit("timeout_pulse_end", bus_timeout, 1'b0);
      @(posedge clk);
      #1 bus_if.bus_ack = 1'b0;
      @(negedge clk);
      check_bit("late_ack_req", bus_if.bus_req, 1'b0);
      check_bit("late_ack_valid", load_valid, 1'b0);
      check("late_ack_data", load_data, exp_load);
   endtask

   initial begin
      logic [5:0] ops [9];
      logic [5:0] op;
      logic       r;
      logic       w;
      ops = '{OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW, 6'h0F};
      checks   = 0;
      errors   = 0;
      exp_load = 32'h0;
      rst      = 1'b1;
      memr_in  = 1'b0;
      memw_in  = 1'b0;
      addr_in  = 32'h0;
      wdata_in = 32'h0;
      instr_in = 32'h0;
      bus_if.bus_ack   = 1'b0;
      bus_if.bus_rdata = 32'h0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_state();
      rst = 1'b0;

      txn(OP_LW,  1'b1, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 3);
      txn(OP_LB,  1'b1, 1'b0, 32'h103, 32'h0, 32'h80112233, 2);
      txn(OP_LBU, 1'b1, 1'b0, 32'h103, 32'h0, 32'h80112233, 1);
      txn(OP_LHU, 1'b1, 1'b0, 32'h102, 32'h0, 32'h80112233, 2);
      txn(OP_LH,  1'b1, 1'b0, 32'h102, 32'h0, 32'h80112233, 4);
      txn(OP_SB,  1'b0, 1'b1, 32'h201, 32'h000000A5, 32'h0, 1);
      txn(OP_SH,  1'b0, 1'b1, 32'h206, 32'h1234BEEF, 32'h0, 2);
      txn(OP_SW,  1'b0, 1'b1, 32'h208, 32'h87654321, 32'h0, 3);
      txn(OP_LW,  1'b1, 1'b0, 32'h102, 32'h0, 32'h0, 1);
      txn(OP_LW,  1'b1, 1'b1, 32'h104, 32'h0, 32'h0, 1);
      txn(OP_LW,  1'b1, 1'b0, 32'h400, 32'h0, 32'h12345678, 0);
      txn(OP_SW,  1'b0, 1'b1, 32'h404, 32'h0BADF00D, 32'h0, 0);
      txn(OP_LH,  1'b1, 1'b0, 32'h402, 32'h0, 32'h9ABC1234, TIMEOUT);
      txn(6'h0F,  1'b1, 1'b0, 32'h500, 32'h0, 32'h55AA33CC, 1);

      for (int i = 0; i < 40; i++) begin
         op = ops[$urandom_range(0, 8)];
         r  = !op[3];
         w  = op[3];
         if ($urandom_range(0, 9) == 0) begin
            r = 1'b1;
            w = 1'b1;
         end
         txn(op, r, w, {20'h00002, 10'($urandom), 2'($urandom)}, $urandom, $urandom,
             int'($urandom_range(1, 5)));
      end

      // Reset while a store is in flight.
      @(negedge clk);
      memw_in  = 1'b1;
      instr_in = {OP_SW, 26'h0};
      addr_in  = 32'h300;
      wdata_in = 32'hCAFEF00D;
      @(posedge clk);
      #1 memw_in = 1'b0;
      @(negedge clk);
      $display("txn op=%h reset during access addr=%h", OP_SW, 32'h300);
      check_bit("pre_rst_req", bus_if.bus_req, 1'b1);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_reset_state();
      exp_load = 32'h0;
      rst = 1'b0;

      txn(OP_LBU, 1'b1, 1'b0, 32'h311, 32'h0, 32'hF0E1D2C3, 2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
